// File: rtl/crop_video_config_rx_pkg.sv
// Shared types and helpers for the crop_video_config bus receiver.
package crop_video_config_rx_pkg;

  // Field width of the crop bus; the receiver's DW parameter must match this.
  localparam int unsigned CROP_DW = 16;

  typedef enum logic [1:0] {IDLE, SETTLE, PENDING, ERROR} state_t;

  typedef struct packed {
    logic [CROP_DW-1:0] x;
    logic [CROP_DW-1:0] y;
    logic [CROP_DW-1:0] w;
    logic [CROP_DW-1:0] h;
  } crop_cfg_t;

  // Sums are one bit wider than the fields so x+w cannot wrap past the frame limit.
  function automatic logic cfg_is_legal(crop_cfg_t c, int unsigned frame_w,
                                        int unsigned frame_h);
    logic [CROP_DW:0] sum_x;
    logic [CROP_DW:0] sum_y;
    sum_x = {1'b0, c.x} + {1'b0, c.w};
    sum_y = {1'b0, c.y} + {1'b0, c.h};
    return (c.w != '0) && (c.h != '0) && (32'(sum_x) <= frame_w) && (32'(sum_y) <= frame_h);
  endfunction

  function automatic logic cfg_is_null(crop_cfg_t c);
    return c == '0;
  endfunction

endpackage

// File: rtl/crop_video_cfg_validator.sv
// Combinational legality / null check of a sampled crop rectangle.
module crop_video_cfg_validator
  import crop_video_config_rx_pkg::*;
#(
  parameter int unsigned FRAME_W = 1920,
  parameter int unsigned FRAME_H = 1080
) (
  input  crop_cfg_t cfg,
  output logic      legal,
  output logic      is_null
);

  // Pure decode of the sampled set; the FSM decides what to do with it.
  always_comb begin
    legal   = cfg_is_legal(cfg, FRAME_W, FRAME_H);
    is_null = cfg_is_null(cfg);
  end

endmodule

// File: rtl/crop_video_config_rx.sv
// Receiver for the level-driven crop_video_config bus: debounces the bus, validates the
// rectangle, stages it and commits it to the active window only at start-of-frame.
module crop_video_config_rx
  import crop_video_config_rx_pkg::*;
#(
  parameter int unsigned DW            = CROP_DW,
  parameter int unsigned FRAME_W       = 1920,
  parameter int unsigned FRAME_H       = 1080,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] crop_x,
  input  logic [DW-1:0] crop_y,
  input  logic [DW-1:0] crop_width,
  input  logic [DW-1:0] crop_height,
  input  logic          sof,
  output logic [DW-1:0] active_x,
  output logic [DW-1:0] active_y,
  output logic [DW-1:0] active_w,
  output logic [DW-1:0] active_h,
  output logic          active_valid,
  output logic          cfg_pending,
  output logic          cfg_commit,
  output logic          cfg_error
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

  crop_cfg_t     bus;
  crop_cfg_t     q;
  crop_cfg_t     pend;
  crop_cfg_t     active;
  logic [CW-1:0] cnt;
  state_t        state;
  logic          changed;
  logic          settled;
  logic          legal;
  logic          is_null;

  // Present the bus as one struct so a change in any field is a single compare.
  always_comb begin
    bus     = '{x: crop_x, y: crop_y, w: crop_width, h: crop_height};
    changed = (bus != q);
    settled = !changed && (cnt == CW'(STABLE_CYCLES));
  end

  assign active_x = active.x;
  assign active_y = active.y;
  assign active_w = active.w;
  assign active_h = active.h;

  crop_video_cfg_validator #(
    .FRAME_W (FRAME_W),
    .FRAME_H (FRAME_H)
  ) u_validator (
    .cfg     (q),
    .legal   (legal),
    .is_null (is_null)
  );

  // Sample register and saturating stability counter; any change restarts the count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q   <= '0;
      cnt <= '0;
    end else if (changed) begin
      q   <= bus;
      cnt <= '0;
    end else if (cnt != CW'(STABLE_CYCLES)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Control FSM with registered status outputs, staged set and active window.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= SETTLE;
      pend         <= '0;
      active       <= '0;
      active_valid <= 1'b0;
      cfg_pending  <= 1'b0;
      cfg_commit   <= 1'b0;
      cfg_error    <= 1'b0;
    end else begin
      cfg_commit <= 1'b0;
      if (state == PENDING && sof) begin
        // Commit wins over a simultaneous bus change; the new value is already in q.
        active       <= pend;
        active_valid <= 1'b1;
        cfg_commit   <= 1'b1;
        cfg_pending  <= 1'b0;
        state        <= changed ? SETTLE : IDLE;
      end else if (changed) begin
        cfg_pending <= 1'b0;
        state       <= SETTLE;
      end else if (state == SETTLE && settled) begin
        if (is_null) begin
          state <= IDLE;
        end else if (legal) begin
          pend        <= q;
          cfg_pending <= 1'b1;
          cfg_error   <= 1'b0;
          state       <= PENDING;
        end else begin
          cfg_error <= 1'b1;
          state     <= ERROR;
        end
      end
    end
  end

endmodule

// File: tb/tb_crop_video_config_rx.sv
// Directed bench for crop_video_config_rx with a commit scoreboard.
module tb_crop_video_config_rx;
  import crop_video_config_rx_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] crop_x = '0;
  logic [15:0] crop_y = '0;
  logic [15:0] crop_width = '0;
  logic [15:0] crop_height = '0;
  logic        sof = 1'b0;
  logic [15:0] active_x, active_y, active_w, active_h;
  logic        active_valid, cfg_pending, cfg_commit, cfg_error;
  logic [63:0] active_win;

  int total = 0;
  int bad = 0;
  int ncommit = 0;
  crop_cfg_t sb[$];

  assign active_win = {active_x, active_y, active_w, active_h};

  crop_video_config_rx #(
    .DW            (16),
    .FRAME_W       (1920),
    .FRAME_H       (1080),
    .STABLE_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .crop_x       (crop_x),
    .crop_y       (crop_y),
    .crop_width   (crop_width),
    .crop_height  (crop_height),
    .sof          (sof),
    .active_x     (active_x),
    .active_y     (active_y),
    .active_w     (active_w),
    .active_h     (active_h),
    .active_valid (active_valid),
    .cfg_pending  (cfg_pending),
    .cfg_commit   (cfg_commit),
    .cfg_error    (cfg_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic crop_cfg_t mk(int x, int y, int w, int h);
    crop_cfg_t c;
    c.x = 16'(x);
    c.y = 16'(y);
    c.w = 16'(w);
    c.h = 16'(h);
    return c;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_bus(input crop_cfg_t c);
    crop_x      = c.x;
    crop_y      = c.y;
    crop_width  = c.w;
    crop_height = c.h;
  endtask

  // Drive a set and verify cfg_pending rises exactly 5 edges after the sampling edge.
  task automatic stage(input string tag, input crop_cfg_t c);
    set_bus(c);
    tick(5);
    check({tag, "_pending_early"}, 64'(cfg_pending), 64'd0);
    tick(1);
    check({tag, "_pending"}, 64'(cfg_pending), 64'd1);
    check({tag, "_error_clear"}, 64'(cfg_error), 64'd0);
  endtask

  // One-cycle sof; afterwards the commit pulse and window are checked.
  task automatic commit(input string tag, input crop_cfg_t c);
    sb.push_back(c);
    sof = 1'b1;
    tick(1);
    sof = 1'b0;
    check({tag, "_commit"}, 64'(cfg_commit), 64'd1);
    check({tag, "_valid"}, 64'(active_valid), 64'd1);
    check({tag, "_pending_drop"}, 64'(cfg_pending), 64'd0);
    tick(1);
    check({tag, "_commit_one_cycle"}, 64'(cfg_commit), 64'd0);
  endtask

  // Scoreboard: every commit pulse must match the oldest expected window.
  always @(negedge clk) begin
    if (cfg_commit === 1'b1) begin
      check("commit_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        check("commit_window", active_win, 64'(sb.pop_front()));
        ncommit++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with bus at 0
    tick(3);
    check("rst_window", active_win, 64'd0);
    check("rst_flags", {active_valid, cfg_pending, cfg_commit, cfg_error}, 64'd0);
    rst = 1'b1;
    tick(6);
    check("rst_idle_error", 64'(cfg_error), 64'd0);
    check("rst_idle_pending", 64'(cfg_pending), 64'd0);

    // Basic legal set and commit
    stage("basic", mk(100, 50, 640, 480));
    commit("basic", mk(100, 50, 640, 480));

    // Illegal: x+w = 2000
    set_bus(mk(1600, 0, 400, 100));
    tick(6);
    check("ill_error", 64'(cfg_error), 64'd1);
    check("ill_pending", 64'(cfg_pending), 64'd0);
    sof = 1'b1;
    tick(1);
    sof = 1'b0;
    check("ill_no_commit", 64'(cfg_commit), 64'd0);
    check("ill_active_kept", active_win, 64'(mk(100, 50, 640, 480)));

    // Full frame clears the error as pending rises
    set_bus(mk(0, 0, 1920, 1080));
    tick(5);
    check("full_error_held", 64'(cfg_error), 64'd1);
    tick(1);
    check("full_pending", 64'(cfg_pending), 64'd1);
    check("full_error_clear", 64'(cfg_error), 64'd0);
    commit("full", mk(0, 0, 1920, 1080));

    // Sums exactly at the limit
    stage("edge", mk(1280, 0, 640, 1080));
    commit("edge", mk(1280, 0, 640, 1080));

    // 17-bit sum 65536 must not wrap
    set_bus(mk(65535, 0, 1, 10));
    tick(6);
    check("wrap_error", 64'(cfg_error), 64'd1);
    check("wrap_pending", 64'(cfg_pending), 64'd0);

    // Stage a set, then replace it with w=0 before sof: discarded, error
    stage("pre_w0", mk(10, 10, 20, 20));
    set_bus(mk(5, 5, 0, 10));
    tick(1);
    check("discard_pending", 64'(cfg_pending), 64'd0);
    tick(5);
    check("w0_error", 64'(cfg_error), 64'd1);
    check("w0_pending", 64'(cfg_pending), 64'd0);
    sof = 1'b1;
    tick(1);
    sof = 1'b0;
    check("w0_no_commit", 64'(cfg_commit), 64'd0);
    check("w0_active_kept", active_win, 64'(mk(1280, 0, 640, 1080)));

    // Null set: error stays, committed window stays
    set_bus(mk(0, 0, 0, 0));
    tick(6);
    check("null_error_kept", 64'(cfg_error), 64'd1);
    check("null_valid_kept", 64'(active_valid), 64'd1);
    check("null_pending", 64'(cfg_pending), 64'd0);

    // Glitching width never settles
    for (int i = 0; i < 6; i++) begin
      set_bus(mk(200, 100, (i % 2) ? 301 : 300, 200));
      tick(2);
      check("glitch_pending", 64'(cfg_pending), 64'd0);
    end
    stage("glitch_hold", mk(200, 100, 300, 200));

    // sof together with a bus change: old set commits, new set goes pending later
    sb.push_back(mk(200, 100, 300, 200));
    set_bus(mk(400, 300, 500, 400));
    sof = 1'b1;
    tick(1);
    sof = 1'b0;
    check("race_commit", 64'(cfg_commit), 64'd1);
    check("race_window_old", active_win, 64'(mk(200, 100, 300, 200)));
    check("race_pending_drop", 64'(cfg_pending), 64'd0);
    tick(4);
    check("race_pending_early", 64'(cfg_pending), 64'd0);
    tick(1);
    check("race_pending", 64'(cfg_pending), 64'd1);
    commit("race_new", mk(400, 300, 500, 400));

    // Reset while pending
    stage("rst_pend", mk(10, 20, 30, 40));
    rst = 1'b0;
    tick(1);
    check("rstp_window", active_win, 64'd0);
    check("rstp_flags", {active_valid, cfg_pending, cfg_commit, cfg_error}, 64'd0);
    rst = 1'b1;
    tick(5);
    check("rstp_restage_early", 64'(cfg_pending), 64'd0);
    tick(1);
    check("rstp_restage", 64'(cfg_pending), 64'd1);
    tick(2);

    check("sb_drained", 64'(sb.size()), 64'd0);
    check("commit_count", 64'(ncommit), 64'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
